// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encodings,
// the bundle of stage-register controls, and the hard-wired zero register.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
package hazard_pkg;

  // Instruction-fetch bus tracking. F_DISCARD means the fetch still in
  // flight belongs to a path abandoned by a redirect.
  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_t;

  // Data-memory bus tracking.
  typedef enum logic {
    D_IDLE = 1'b0,
    D_WAIT = 1'b1
  } dmem_state_t;

  // Register x0 is hard-wired to zero, so a load into it never creates a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Every enable/clear this block drives into the PC and stage registers.
  typedef struct packed {
    logic pc_stall;
    logic pc_redirect;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts cycles with en=1, holds at all-ones,
// synchronous clear. Used for the hazard performance counters.
module hazard_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count qualifying cycles, sticking at the maximum value.
  always_ff @(posedge clk) begin
    // NOTE: registered state is written with <= so every flop samples the
    // pre-edge values and simulation order cannot change the result.
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for the 5-stage RV32 pipeline. It covers the hazards
// the forwarding unit cannot bypass: load-use, instruction-fetch wait,
// data-memory wait and taken-branch redirect (including discard of a fetch
// that is still in flight on the abandoned path).
// Build option: define HAZARD_PERF_EN to add three saturating perf counters;
// otherwise the perf_* outputs are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      idex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] idex_rd_addr,
  input  logic                      ex_branch_taken,
  input  logic                      imem_req,
  input  logic                      imem_ack,
  input  logic                      dmem_req,
  input  logic                      dmem_ack,
  output logic                      pc_stall,
  output logic                      pc_redirect,
  output logic                      ifid_stall,
  output logic                      ifid_flush,
  output logic                      idex_stall,
  output logic                      idex_flush,
  output logic                      exmem_stall,
  output logic                      memwb_flush,
  output logic [CNT_WIDTH-1:0]      perf_loaduse_cnt,
  output logic [CNT_WIDTH-1:0]      perf_dmem_cnt,
  output logic [CNT_WIDTH-1:0]      perf_redirect_cnt
);

  fetch_state_t fetch_state, fetch_next;
  dmem_state_t  dmem_state, dmem_next;
  hazard_ctrl_t ctrl;

  logic dmem_busy;
  logic imem_busy;
  logic load_use;
  logic fetch_wait;

  assign dmem_busy = dmem_req & ~dmem_ack;
  assign imem_busy = imem_req & ~imem_ack;

  // A load whose result the ID instruction needs next cycle; x0 is exempt
  // because its value never changes.
  assign load_use = idex_mem_read
                  && (idex_rd_addr != REG_ADDR_WIDTH'(REG_X0))
                  && ((id_use_rs1 && (id_rs1_addr == idex_rd_addr))
                   || (id_use_rs2 && (id_rs2_addr == idex_rd_addr)));

  // IF has no usable word this cycle: either the bus is still busy, or the
  // word in flight is stale and will be dropped when it lands.
  assign fetch_wait = imem_busy || (fetch_state == F_DISCARD);

  // Bus-tracking state registers with synchronous reset to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_state <= F_IDLE;
      dmem_state  <= D_IDLE;
    end else begin
      fetch_state <= fetch_next;
      dmem_state  <= dmem_next;
    end
  end

  // Prioritised stage controls and FSM next-state.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would infer a latch.
    ctrl       = '0;
    fetch_next = fetch_state;
    dmem_next  = dmem_state;

    if (rst) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (dmem_busy) begin
      // Freeze everything up to EX/MEM and bubble WB; a branch or load-use
      // waits until the pipeline moves again.
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Redirect overrides any fetch wait; the two younger instructions die.
      ctrl.pc_redirect = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
    end else if (load_use) begin
      // Keep ID and hold PC for one bubble; takes precedence over a fetch
      // wait so the ID instruction is not lost.
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_flush  = 1'b1;
    end else if (fetch_wait) begin
      // Covers the discard ack cycle too: the stale word is replaced by NOP.
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_flush  = 1'b1;
    end

    unique case (fetch_state)
      F_IDLE: begin
        if (imem_busy) fetch_next = F_WAIT;
      end
      F_WAIT: begin
        // A redirect coinciding with the ack is already flushed by the
        // branch priority, so only a redirect without ack needs discarding.
        if (imem_ack)              fetch_next = F_IDLE;
        else if (ctrl.pc_redirect) fetch_next = F_DISCARD;
      end
      F_DISCARD: begin
        if (imem_ack) fetch_next = F_IDLE;
      end
      default: fetch_next = F_IDLE;
    endcase

    unique case (dmem_state)
      D_IDLE:  if (dmem_busy) dmem_next = D_WAIT;
      D_WAIT:  if (dmem_ack)  dmem_next = D_IDLE;
      default: dmem_next = D_IDLE;
    endcase
  end

  // Bus sanity: a data ack with no transfer outstanding means a broken master.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((dmem_state != D_IDLE) || !dmem_ack || dmem_req);
    end
  end

  assign pc_stall    = ctrl.pc_stall;
  assign pc_redirect = ctrl.pc_redirect;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_stall  = ctrl.idex_stall;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_stall = ctrl.exmem_stall;
  assign memwb_flush = ctrl.memwb_flush;

`ifdef HAZARD_PERF_EN
  logic                 loaduse_bubble;
  logic [CNT_WIDTH-1:0] loaduse_q;
  logic [CNT_WIDTH-1:0] dmem_q;
  logic [CNT_WIDTH-1:0] redirect_q;

  // Count only bubbles actually inserted, not load-use hidden by a higher priority.
  assign loaduse_bubble = load_use & ~dmem_busy & ~ex_branch_taken;

  hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_loaduse_cnt (
    .clk   (clk),
    .en    (loaduse_bubble),
    .clr   (rst),
    .count (loaduse_q)
  );

  hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_dmem_cnt (
    .clk   (clk),
    .en    (dmem_busy),
    .clr   (rst),
    .count (dmem_q)
  );

  hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
    .clk   (clk),
    .en    (ctrl.pc_redirect),
    .clr   (rst),
    .count (redirect_q)
  );

  // Counters read as zero throughout reset, not just after the clearing edge.
  assign perf_loaduse_cnt  = rst ? '0 : loaduse_q;
  assign perf_dmem_cnt     = rst ? '0 : dmem_q;
  assign perf_redirect_cnt = rst ? '0 : redirect_q;
`else
  assign perf_loaduse_cnt  = '0;
  assign perf_dmem_cnt     = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies one stimulus
// vector per cycle and queues the response predicted by a behavioural model;
// a monitor on the falling edge pops and compares against the DUT.
module tb_pipeline_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] id_rs1_addr = '0, id_rs2_addr = '0, idex_rd_addr = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, idex_mem_read = 1'b0;
  logic ex_branch_taken = 1'b0;
  logic imem_req = 1'b0, imem_ack = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic pc_stall, pc_redirect, ifid_stall, ifid_flush;
  logic idex_stall, idex_flush, exmem_stall, memwb_flush;
  logic [CW-1:0] perf_loaduse_cnt, perf_dmem_cnt, perf_redirect_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs1_addr       (id_rs1_addr),
    .id_rs2_addr       (id_rs2_addr),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .idex_mem_read     (idex_mem_read),
    .idex_rd_addr      (idex_rd_addr),
    .ex_branch_taken   (ex_branch_taken),
    .imem_req          (imem_req),
    .imem_ack          (imem_ack),
    .dmem_req          (dmem_req),
    .dmem_ack          (dmem_ack),
    .pc_stall          (pc_stall),
    .pc_redirect       (pc_redirect),
    .ifid_stall        (ifid_stall),
    .ifid_flush        (ifid_flush),
    .idex_stall        (idex_stall),
    .idex_flush        (idex_flush),
    .exmem_stall       (exmem_stall),
    .memwb_flush       (memwb_flush),
    .perf_loaduse_cnt  (perf_loaduse_cnt),
    .perf_dmem_cnt     (perf_dmem_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
  );

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs1, rs2, rd;
    logic          use1, use2, mr, br, ireq, iack, dreq, dack;
  } stim_t;

  // Control bits ordered: pc_stall, pc_redirect, ifid_stall, ifid_flush,
  // idex_stall, idex_flush, exmem_stall, memwb_flush.
  typedef struct packed {
    logic [7:0]    ctrl;
    logic [CW-1:0] lu, dm, rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0, n_issued = 0, n_popped = 0;

  // Model state: a fetch the pipeline still wants, a fetch to be thrown away,
  // and the three event counts since the last reset.
  bit   m_fetch_wanted = 0, m_fetch_stale = 0;
  int   m_lu = 0, m_dm = 0, m_rd = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Predict this cycle's outputs from the rules, then advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    bit dbusy, lu, fwait;
    bit p_st, p_rd, if_st, if_fl, ix_st, ix_fl, em_st, mw_fl;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1_addr = s.rs1; id_rs2_addr = s.rs2; idex_rd_addr = s.rd;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; idex_mem_read = s.mr;
    ex_branch_taken = s.br; imem_req = s.ireq; imem_ack = s.iack;
    dmem_req = s.dreq; dmem_ack = s.dack;

    dbusy = s.dreq && !s.dack;
    lu    = s.mr && (s.rd != 0) && ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    fwait = (s.ireq && !s.iack) || m_fetch_stale;
    {p_st, p_rd, if_st, if_fl, ix_st, ix_fl, em_st, mw_fl} = '0;
    if (s.rst)      begin if_fl = 1; ix_fl = 1; mw_fl = 1; end
    else if (dbusy) begin p_st = 1; if_st = 1; ix_st = 1; em_st = 1; mw_fl = 1; end
    else if (s.br)  begin p_rd = 1; if_fl = 1; ix_fl = 1; end
    else if (lu)    begin p_st = 1; if_st = 1; ix_fl = 1; end
    else if (fwait) begin p_st = 1; if_fl = 1; end

    e.ctrl = {p_st, p_rd, if_st, if_fl, ix_st, ix_fl, em_st, mw_fl};
`ifdef HAZARD_PERF_EN
    e.lu = s.rst ? '0 : CW'(m_lu);
    e.dm = s.rst ? '0 : CW'(m_dm);
    e.rd = s.rst ? '0 : CW'(m_rd);
`else
    e.lu = '0; e.dm = '0; e.rd = '0;
`endif
    exp_q.push_back(e);
    n_issued++;

    if (s.rst) begin
      m_fetch_wanted = 0; m_fetch_stale = 0; m_lu = 0; m_dm = 0; m_rd = 0;
    end else begin
      if (p_st && if_st && ix_fl && m_lu < CMAX) m_lu++;
      if (dbusy && m_dm < CMAX) m_dm++;
      if (p_rd && m_rd < CMAX) m_rd++;
      if (m_fetch_stale) begin
        if (s.iack) m_fetch_stale = 0;
      end else if (m_fetch_wanted) begin
        if (s.iack) m_fetch_wanted = 0;
        else if (p_rd) begin m_fetch_wanted = 0; m_fetch_stale = 1; end
      end else if (s.ireq && !s.iack) begin
        m_fetch_wanted = 1;
      end
    end
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_popped++;
      check("ctrl", {pc_stall, pc_redirect, ifid_stall, ifid_flush,
                     idex_stall, idex_flush, exmem_stall, memwb_flush}, mon_e.ctrl);
      check("loaduse_cnt", perf_loaduse_cnt, mon_e.lu);
      check("dmem_cnt", perf_dmem_cnt, mon_e.dm);
      check("redirect_cnt", perf_redirect_cnt, mon_e.rd);
      check("ifid_stall_and_flush", ifid_stall & ifid_flush, 1'b0);
      check("idex_stall_and_flush", idex_stall & idex_flush, 1'b0);
    end
  end

  function automatic logic [AW-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return AW'(0);
      1:       return AW'(1);
      2:       return AW'(5);
      default: return AW'(7);
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s      = '0;
    s.rst  = ($urandom_range(0, 63) == 0);
    s.rs1  = pick_reg();
    s.rs2  = pick_reg();
    s.rd   = pick_reg();
    s.use1 = 1'($urandom_range(0, 1));
    s.use2 = 1'($urandom_range(0, 1));
    s.mr   = ($urandom_range(0, 2) == 0);
    s.br   = ($urandom_range(0, 5) == 0);
    s.ireq = ($urandom_range(0, 3) != 0);
    s.iack = ($urandom_range(0, 2) == 0);
    s.dreq = ($urandom_range(0, 3) == 0);
    s.dack = s.dreq && ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;

    // Reset
    s = idle(); s.rst = 1; apply(s); apply(s);
    s = idle(); apply(s);

    // Load-use on rs2: one bubble, then the load has moved on
    s = idle(); s.mr = 1; s.rd = 5; s.rs2 = 5; s.use2 = 1; apply(s);
    s = idle(); apply(s);

    // Load into x0 never stalls
    s = idle(); s.mr = 1; s.rd = 0; s.rs1 = 0; s.use1 = 1; apply(s);

    // Data-memory wait of 3 cycles, released on the ack
    s = idle(); s.dreq = 1; repeat (3) apply(s);
    s.dack = 1; apply(s);
    s = idle(); apply(s);

    // Branch held while dmem busy: redirect only on the ack cycle
    s = idle(); s.dreq = 1; s.br = 1; repeat (2) apply(s);
    s.dack = 1; apply(s);
    s = idle(); apply(s);

    // Redirect during a pending fetch; stale word dropped on its ack
    s = idle(); s.ireq = 1; apply(s);
    s.br = 1; apply(s);
    s.br = 0; apply(s);
    s.iack = 1; apply(s);
    s = idle(); apply(s);

    // Redirect coinciding with the fetch ack: no discard afterwards
    s = idle(); s.ireq = 1; apply(s);
    s.br = 1; s.iack = 1; apply(s);
    s = idle(); apply(s);

    // Reset mid-fetch, then a stray ack
    s = idle(); s.ireq = 1; apply(s);
    s.rst = 1; apply(s);
    s = idle(); s.iack = 1; apply(s);
    s = idle(); apply(s);

    // Load-use and fetch wait together: ID kept
    s = idle(); s.mr = 1; s.rd = 7; s.rs1 = 7; s.use1 = 1; s.ireq = 1; apply(s);
    s = idle(); s.iack = 1; s.ireq = 1; apply(s);

    // Drive the load-use counter into saturation
    s = idle(); s.mr = 1; s.rd = 1; s.rs1 = 1; s.use1 = 1;
    repeat (CMAX + 5) apply(s);
    s = idle(); apply(s); apply(s);

    // Randomised traffic
    repeat (3000) apply(rand_stim());
    s = idle(); apply(s);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drain", n_popped, n_issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
